// File: rtl/brc_pkg.sv
// Shared types and the funct3 taken decode for the iterative branch comparator.
package brc_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } brc_state_e;

    // Reserved encodings 010/011 never take the branch.
    function automatic logic br_taken(input logic [2:0] op, input logic less, input logic equal);
        case (op)
            BEQ:        return equal;
            BNE:        return !equal;
            BLT, BLTU:  return less;
            BGE, BGEU:  return !less;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/brc_slice_cmp.sv
// Combinational CHUNK_W-bit slice compare; the top slice of a signed op has its MSB flipped.
module brc_slice_cmp #(
    parameter int CHUNK_W = 8
) (
    input  logic [CHUNK_W-1:0] a_i,
    input  logic [CHUNK_W-1:0] b_i,
    input  logic               is_msb_signed_i,
    output logic               lt_o,
    output logic               eq_o
);

    logic [CHUNK_W-1:0] flip;
    logic [CHUNK_W-1:0] a_m;
    logic [CHUNK_W-1:0] b_m;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign flip = CHUNK_W'(is_msb_signed_i) << (CHUNK_W - 1);
    assign a_m  = a_i ^ flip;
    assign b_m  = b_i ^ flip;
    assign lt_o = (a_m < b_m);
    assign eq_o = (a_i == b_i);

endmodule

// File: rtl/brc_iter.sv
// Multi-cycle branch comparator: scans operands MSB slice first, optional early exit on first difference.
module brc_iter
    import brc_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int CHUNK_W    = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_rs1_data,
    input  logic [DATA_W-1:0] i_rs2_data,
    input  logic [2:0]        i_br_op,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_br_less,
    output logic              o_br_equal,
    output logic              o_br_taken
);

    localparam int NCHUNK = DATA_W / CHUNK_W;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    brc_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [2:0]        op_q;
    logic              decided_q;
    logic              less_q;
    logic              valid_q;
    logic              br_less_q;
    logic              br_equal_q;
    logic              br_taken_q;

    logic              slice_lt;
    logic              slice_eq;
    logic              signed_top;
    logic              decided_d;
    logic              less_d;
    logic              finish;
    logic              accept;

    // Operands shift left each CMP cycle, so the slice under test is always the top one.
    assign signed_top = !op_q[1] && (cnt_q == '0);

    brc_slice_cmp #(.CHUNK_W(CHUNK_W)) u_slice (
        .a_i             (a_q[DATA_W-1 -: CHUNK_W]),
        .b_i             (b_q[DATA_W-1 -: CHUNK_W]),
        .is_msb_signed_i (signed_top),
        .lt_o            (slice_lt),
        .eq_o            (slice_eq)
    );

    assign decided_d = decided_q | ~slice_eq;
    assign less_d    = decided_q ? less_q : (~slice_eq & slice_lt);
    assign finish    = (decided_d & EARLY_EXIT) | (cnt_q == LAST);
    assign accept    = (state_q == IDLE) & i_valid & ~i_flush;

    always_ff @(posedge i_clk) begin
        if (accept) begin
            a_q  <= i_rs1_data;
            b_q  <= i_rs2_data;
            op_q <= i_br_op;
        end else if (state_q == CMP) begin
            a_q  <= a_q << CHUNK_W;
            b_q  <= b_q << CHUNK_W;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            decided_q  <= 1'b0;
            less_q     <= 1'b0;
            valid_q    <= 1'b0;
            br_less_q  <= 1'b0;
            br_equal_q <= 1'b0;
            br_taken_q <= 1'b0;
        end else if (i_flush) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        state_q   <= CMP;
                        cnt_q     <= '0;
                        decided_q <= 1'b0;
                        less_q    <= 1'b0;
                    end
                end
                CMP: begin
                    decided_q <= decided_d;
                    less_q    <= less_d;
                    if (finish) begin
                        state_q    <= DONE;
                        valid_q    <= 1'b1;
                        br_less_q  <= less_d;
                        br_equal_q <= ~decided_d;
                        br_taken_q <= br_taken(op_q, less_d, ~decided_d);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready    = (state_q == IDLE);
    assign o_valid    = valid_q;
    assign o_br_less  = br_less_q;
    assign o_br_equal = br_equal_q;
    assign o_br_taken = br_taken_q;

endmodule

// File: tb/tb_brc_iter.sv
// Directed bench for brc_iter: latency, decode, hold, flush and reset scenarios.
module tb_brc_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [2:0]  op = 3'b000;
    logic        ready = 1'b1;

    logic        o_ready, o_valid, o_less, o_equal, o_taken;
    logic        o_ready2, o_valid2, o_less2, o_equal2, o_taken2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    brc_iter #(.DATA_W(32), .CHUNK_W(8), .EARLY_EXIT(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(o_ready),
        .i_rs1_data(rs1), .i_rs2_data(rs2), .i_br_op(op), .o_valid(o_valid), .i_ready(ready),
        .o_br_less(o_less), .o_br_equal(o_equal), .o_br_taken(o_taken)
    );

    brc_iter #(.DATA_W(32), .CHUNK_W(8), .EARLY_EXIT(1'b0)) dut_fixed (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(o_ready2),
        .i_rs1_data(rs1), .i_rs2_data(rs2), .i_br_op(op), .o_valid(o_valid2), .i_ready(ready),
        .o_br_less(o_less2), .o_br_equal(o_equal2), .o_br_taken(o_taken2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request, then wait for o_valid; lat counts edges from the accept edge (inclusive).
    task automatic run_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           output int lat);
        op = f3; rs1 = a; rs2 = b; valid = 1'b1;
        tick();
        valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        checks++; if ({o_less, o_equal, o_taken} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {o_less, o_equal, o_taken}); end
        checks++; if (o_ready2 !== 1'b1) begin failures++; $display("FAIL reset_ready_fixed got=%b exp=1", o_ready2); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_beq_equal();
        int lat1 = 0;
        int lat2 = 0;
        logic [2:0] f1 = 3'b000;
        logic [2:0] f2 = 3'b000;
        op = 3'b000; rs1 = 32'h1234_5678; rs2 = 32'h1234_5678; ready = 1'b1; valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int c = 2; c <= 20; c++) begin
            tick();
            if (o_valid && lat1 == 0) begin lat1 = c; f1 = {o_less, o_equal, o_taken}; end
            if (o_valid2 && lat2 == 0) begin lat2 = c; f2 = {o_less2, o_equal2, o_taken2}; end
            if (lat1 != 0 && lat2 != 0) break;
        end
        checks++; if (lat1 != 5) begin failures++; $display("FAIL beq_lat got=%0d exp=5", lat1); end
        checks++; if (lat2 != 5) begin failures++; $display("FAIL beq_lat_fixed got=%0d exp=5", lat2); end
        checks++; if (f1 !== 3'b011) begin failures++; $display("FAIL beq_flags got=%b exp=011", f1); end
        checks++; if (f2 !== 3'b011) begin failures++; $display("FAIL beq_flags_fixed got=%b exp=011", f2); end
        tick(); tick();
    endtask

    task automatic test_bltu_first_slice();
        int lat;
        ready = 1'b1;
        run_req(3'b110, 32'h0000_0000, 32'hFFFF_FFFF, lat);
        checks++; if (lat != 2) begin failures++; $display("FAIL bltu_lat got=%0d exp=2", lat); end
        checks++; if ({o_less, o_equal, o_taken} !== 3'b101) begin failures++; $display("FAIL bltu_flags got=%b exp=101", {o_less, o_equal, o_taken}); end
        tick();
        checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin failures++; $display("FAIL bltu_release got=%b%b exp=10", o_ready, o_valid); end
    endtask

    task automatic test_signed();
        int lat;
        run_req(3'b100, 32'h8000_0000, 32'h0000_0001, lat);
        checks++; if (lat != 2) begin failures++; $display("FAIL blt_lat got=%0d exp=2", lat); end
        checks++; if ({o_less, o_taken} !== 2'b11) begin failures++; $display("FAIL blt_flags got=%b exp=11", {o_less, o_taken}); end
        tick();
        run_req(3'b110, 32'h8000_0000, 32'h0000_0001, lat);
        checks++; if (lat != 2) begin failures++; $display("FAIL bltu_neg_lat got=%0d exp=2", lat); end
        checks++; if ({o_less, o_equal, o_taken} !== 3'b000) begin failures++; $display("FAIL bltu_neg_flags got=%b exp=000", {o_less, o_equal, o_taken}); end
        tick();
    endtask

    task automatic test_hold();
        int lat;
        ready = 1'b0;
        run_req(3'b111, 32'h0000_00FF, 32'h0000_00FE, lat);
        checks++; if (lat != 5) begin failures++; $display("FAIL bgeu_lat got=%0d exp=5", lat); end
        checks++; if ({o_less, o_equal, o_taken} !== 3'b001) begin failures++; $display("FAIL bgeu_flags got=%b exp=001", {o_less, o_equal, o_taken}); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({o_valid, o_ready, o_less, o_equal, o_taken} !== 5'b10001) begin
                failures++; $display("FAIL hold_%0d got=%b exp=10001", i, {o_valid, o_ready, o_less, o_equal, o_taken});
            end
        end
        ready = 1'b1;
        tick();
        checks++; if ({o_valid, o_ready} !== 2'b01) begin failures++; $display("FAIL hold_release got=%b exp=01", {o_valid, o_ready}); end
    endtask

    task automatic test_flush_mid();
        int seen = 0;
        op = 3'b001; rs1 = 32'h0000_0001; rs2 = 32'h0000_0000; valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if ({o_ready, o_valid} !== 2'b10) begin failures++; $display("FAIL flush_state got=%b exp=10", {o_ready, o_valid}); end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (o_valid) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL flush_no_valid got=%0d exp=0", seen); end
    endtask

    task automatic test_reset_mid();
        op = 3'b001; rs1 = 32'h0000_0001; rs2 = 32'h0000_0000; valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if ({o_ready, o_valid, o_less, o_equal, o_taken} !== 5'b10000) begin
            failures++; $display("FAIL rst_mid got=%b exp=10000", {o_ready, o_valid, o_less, o_equal, o_taken});
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_op010();
        int lat;
        run_req(3'b010, 32'h0000_0005, 32'h0000_0007, lat);
        checks++; if (lat != 5) begin failures++; $display("FAIL op010_lat got=%0d exp=5", lat); end
        checks++; if ({o_less, o_equal, o_taken} !== 3'b100) begin failures++; $display("FAIL op010_flags got=%b exp=100", {o_less, o_equal, o_taken}); end
        tick();
    endtask

    task automatic test_flush_with_valid();
        int seen = 0;
        op = 3'b000; rs1 = 32'h1; rs2 = 32'h1; valid = 1'b1; flush = 1'b1;
        tick();
        valid = 1'b0; flush = 1'b0;
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL flush_valid_ready got=%b exp=1", o_ready); end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (o_valid) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL flush_valid_capture got=%0d exp=0", seen); end
    endtask

    task automatic test_back_to_back();
        int lat;
        op = 3'b000; rs1 = 32'h1234_5678; rs2 = 32'h1234_5678; valid = 1'b1;
        tick();
        valid = 1'b0;
        // Operand and op changes while comparing must be ignored.
        rs2 = 32'hDEAD_BEEF; op = 3'b001;
        tick();
        checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL b2b_busy got=%b exp=0", o_ready); end
        lat = 2;
        while (!o_valid && lat < 20) begin tick(); lat++; end
        checks++; if (lat != 5) begin failures++; $display("FAIL b2b_lat got=%0d exp=5", lat); end
        checks++; if ({o_less, o_equal, o_taken} !== 3'b011) begin failures++; $display("FAIL b2b_flags got=%b exp=011", {o_less, o_equal, o_taken}); end
        tick();
        run_req(3'b101, 32'hFFFF_FFFF, 32'h0000_0000, lat);
        checks++; if (lat != 2) begin failures++; $display("FAIL b2b_bge_lat got=%0d exp=2", lat); end
        checks++; if ({o_less, o_equal, o_taken} !== 3'b100) begin failures++; $display("FAIL b2b_bge_flags got=%b exp=100", {o_less, o_equal, o_taken}); end
        tick();
    endtask

    initial begin
        test_reset();
        test_beq_equal();
        test_bltu_first_slice();
        test_signed();
        test_hold();
        test_flush_mid();
        test_reset_mid();
        test_op010();
        test_flush_with_valid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
